// File: rtl/hls_csr_pkg.sv
// hls_csr_pkg: register map, CTRL/STATUS bit positions and run-state encoding for hls_csr.
package hls_csr_pkg;

    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_STATUS   = 1;
    localparam int ADDR_RUN_CNT  = 2;
    localparam int ADDR_CYC_CNT  = 3;
    localparam int ADDR_PTR_BASE = 4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {IDLE, START, RUN} state_e;

endpackage

// File: rtl/hls_csr_ptr_bank.sv
// hls_csr_ptr_bank: NUM_PTR x 64-bit pointer bank, written and read as 32-bit lo/hi words.
module hls_csr_ptr_bank #(
    parameter int NUM_PTR = 2,
    parameter int ADDR_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     sel_i,
    input  logic [31:0]           wdata_i,
    output logic                  hit_o,
    output logic [31:0]           rdata_o,
    output logic [64*NUM_PTR-1:0] ptr_o
);

    logic [2*NUM_PTR-1:0][31:0] word_q;

    assign ptr_o = word_q;

    // sel_i is offset from the pointer base; addresses below it wrap past the bank and miss
    always_comb begin
        hit_o   = 1'b0;
        rdata_o = '0;
        for (int i = 0; i < 2*NUM_PTR; i++) begin
            if (sel_i == ADDR_W'(i)) begin
                hit_o   = 1'b1;
                rdata_o = word_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_q <= '0;
        end else begin
            for (int i = 0; i < 2*NUM_PTR; i++) begin
                if (we_i && sel_i == ADDR_W'(i)) word_q[i] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/hls_csr.sv
// hls_csr: Avalon-MM CSR block for one HLS kernel (pointers, start/ready/done handshake, status, counters).
// Optional completion interrupt enabled by defining HLS_CSR_IRQ_EN.
module hls_csr
    import hls_csr_pkg::*;
#(
    parameter int NUM_PTR = 2,
    parameter int ADDR_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_W-1:0]     slv_address,
    input  logic [31:0]           slv_writedata,
    input  logic                  slv_write,
    input  logic                  slv_read,
    output logic [31:0]           slv_readdata,
    output logic                  slv_readdata_valid,
    output logic                  slv_waitrequest,
    output logic                  krn_start_o,
    input  logic                  krn_ready_i,
    input  logic                  krn_done_i,
    output logic [64*NUM_PTR-1:0] ptr_o,
    output logic                  irq_o
);

    state_e      state_q, state_d;
    logic        done_q, done_d, err_q, err_d;
    logic [31:0] run_q, run_d, cyc_q, cyc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;
    logic        busy, wr_ctrl, wr_stat, start_req, complete, ptr_hit, irq_en_rd;
    logic [31:0] ptr_rd;

    assign busy      = state_q != IDLE;
    assign wr_ctrl   = slv_write && slv_address == ADDR_W'(ADDR_CTRL);
    assign wr_stat   = slv_write && slv_address == ADDR_W'(ADDR_STATUS);
    assign start_req = wr_ctrl && slv_writedata[CTRL_START];
    assign complete  = (state_q == RUN && krn_done_i) || (state_q == START && krn_ready_i && krn_done_i);

    assign krn_start_o        = state_q == START;
    assign slv_waitrequest    = 1'b0;
    assign slv_readdata       = rdata_q;
    assign slv_readdata_valid = rvalid_q;

    hls_csr_ptr_bank #(.NUM_PTR(NUM_PTR), .ADDR_W(ADDR_W)) u_ptr_bank (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (slv_write && !busy),
        .sel_i   (slv_address - ADDR_W'(ADDR_PTR_BASE)),
        .wdata_i (slv_writedata),
        .hit_o   (ptr_hit),
        .rdata_o (ptr_rd),
        .ptr_o   (ptr_o)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req) state_d = START;
            START:   if (krn_ready_i) state_d = krn_done_i ? IDLE : RUN;
            RUN:     if (krn_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // a completion in the same cycle as a DONE clear keeps DONE set
    always_comb begin
        done_d  = complete || (done_q && !(wr_stat && slv_writedata[ST_DONE]));
        err_d   = (busy && (start_req || (slv_write && ptr_hit))) ||
                  (err_q && !(wr_stat && slv_writedata[ST_ERR]));
        run_d   = complete ? run_q + 32'd1 : run_q;
        cyc_d   = (!busy && start_req) ? 32'd0 :
                  (busy && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;
        rdata_d = slv_address == ADDR_W'(ADDR_CTRL)    ? {30'd0, irq_en_rd, 1'b0} :
                  slv_address == ADDR_W'(ADDR_STATUS)  ? {29'd0, err_q, done_q, busy} :
                  slv_address == ADDR_W'(ADDR_RUN_CNT) ? run_q :
                  slv_address == ADDR_W'(ADDR_CYC_CNT) ? cyc_q : ptr_rd;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            run_q    <= '0;
            cyc_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
            run_q    <= run_d;
            cyc_q    <= cyc_d;
            rdata_q  <= slv_read ? rdata_d : 32'd0;
            rvalid_q <= slv_read;
        end
    end

`ifdef HLS_CSR_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;

    assign irq_en_d  = wr_ctrl ? slv_writedata[CTRL_IRQ_EN] : irq_en_q;
    assign irq_en_rd = irq_en_q;
    assign irq_o     = irq_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d && irq_en_d;
        end
    end
`else
    assign irq_en_rd = 1'b0;
    assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_hls_csr.sv
// tb_hls_csr: directed self-checking bench for hls_csr (map, run handshake, protection, W1C, async reset).
module tb_hls_csr;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic [3:0]   slv_address = '0;
    logic [31:0]  slv_writedata = '0;
    logic         slv_write = 1'b0;
    logic         slv_read = 1'b0;
    logic [31:0]  slv_readdata;
    logic         slv_readdata_valid;
    logic         slv_waitrequest;
    logic         krn_start_o;
    logic         krn_ready_i = 1'b0;
    logic         krn_done_i = 1'b0;
    logic [127:0] ptr_o;
    logic         irq_o;

    int checks = 0;
    int failures = 0;

    hls_csr #(.NUM_PTR(2), .ADDR_W(4)) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .slv_address        (slv_address),
        .slv_writedata      (slv_writedata),
        .slv_write          (slv_write),
        .slv_read           (slv_read),
        .slv_readdata       (slv_readdata),
        .slv_readdata_valid (slv_readdata_valid),
        .slv_waitrequest    (slv_waitrequest),
        .krn_start_o        (krn_start_o),
        .krn_ready_i        (krn_ready_i),
        .krn_done_i         (krn_done_i),
        .ptr_o              (ptr_o),
        .irq_o              (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; write is sampled at the next posedge, returns at the following negedge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        slv_address = a;
        slv_writedata = d;
        slv_write = 1'b1;
        @(negedge clk_i);
        slv_write = 1'b0;
    endtask

    // called at a negedge; checks data/valid one cycle later and valid low the cycle after
    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        slv_address = a;
        slv_read = 1'b1;
        @(posedge clk_i);
        #1 slv_read = 1'b0;
        chk({tag, "_valid"}, {63'd0, slv_readdata_valid}, 64'd1);
        chk(tag, {32'd0, slv_readdata}, {32'd0, exp});
        @(posedge clk_i);
        #1 chk({tag, "_valid_drop"}, {63'd0, slv_readdata_valid}, 64'd0);
        @(negedge clk_i);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_start", {63'd0, krn_start_o}, 64'd0);
        chk("rst_irq", {63'd0, irq_o}, 64'd0);
        chk("rst_ptr0", ptr_o[63:0], 64'd0);
        chk("rst_rvalid", {63'd0, slv_readdata_valid}, 64'd0);
        chk("rst_rdata", {32'd0, slv_readdata}, 64'd0);
        chk("waitreq", {63'd0, slv_waitrequest}, 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int a = 0; a < 16; a++) rd($sformatf("rst_map%0d", a), 4'(a), 32'd0);

        wr(4'd4, 32'hDEADBEEF);
        wr(4'd5, 32'h1);
        chk("ptr0", ptr_o[63:0], 64'h1_DEADBEEF);
        rd("ptr0_lo", 4'd4, 32'hDEADBEEF);
        rd("ptr0_hi", 4'd5, 32'h1);
        wr(4'd15, 32'hFFFF_FFFF);
        wr(4'd2, 32'h55);
        rd("unmapped15", 4'd15, 32'd0);
        rd("runcnt_ro", 4'd2, 32'd0);

        // run 1: ready in the 3rd start cycle, done in the 10th busy cycle
        wr(4'd0, 32'h1);
        chk("run1_start_c1", {63'd0, krn_start_o}, 64'd1);
        @(negedge clk_i);
        chk("run1_start_c2", {63'd0, krn_start_o}, 64'd1);
        @(negedge clk_i);
        chk("run1_start_c3", {63'd0, krn_start_o}, 64'd1);
        krn_ready_i = 1'b1;
        @(negedge clk_i);
        krn_ready_i = 1'b0;
        chk("run1_start_drop", {63'd0, krn_start_o}, 64'd0);
        repeat (6) @(negedge clk_i);
        krn_done_i = 1'b1;
        @(negedge clk_i);
        krn_done_i = 1'b0;
        rd("run1_status", 4'd1, 32'h2);
        rd("run1_runcnt", 4'd2, 32'd1);
        rd("run1_cyccnt", 4'd3, 32'd10);
        rd("run1_ctrl", 4'd0, 32'd0);

        // run 2: pointer write and second START while busy are dropped
        wr(4'd0, 32'h1);
        wr(4'd6, 32'h12345678);
        wr(4'd0, 32'h1);
        rd("run2_status_busy", 4'd1, 32'h7);
        chk("run2_ptr1", ptr_o[127:64], 64'd0);
        chk("run2_ptr0", ptr_o[63:0], 64'h1_DEADBEEF);
        chk("run2_start_held", {63'd0, krn_start_o}, 64'd1);
        krn_ready_i = 1'b1;
        @(negedge clk_i);
        krn_ready_i = 1'b0;
        krn_done_i = 1'b1;
        @(negedge clk_i);
        krn_done_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("run2_no_restart", {63'd0, krn_start_o}, 64'd0);
        rd("run2_status", 4'd1, 32'h6);
        rd("run2_runcnt", 4'd2, 32'd2);
        rd("run2_cyccnt", 4'd3, 32'd6);
        rd("run2_ptr1_rd", 4'd6, 32'd0);
        wr(4'd1, 32'h6);
        rd("w1c_status", 4'd1, 32'd0);

        // run 3: DONE clear collides with done_i, IRQ_EN requested
        wr(4'd0, 32'h3);
        krn_ready_i = 1'b1;
        @(negedge clk_i);
        krn_ready_i = 1'b0;
        slv_address = 4'd1;
        slv_writedata = 32'h2;
        slv_write = 1'b1;
        krn_done_i = 1'b1;
        @(negedge clk_i);
        slv_write = 1'b0;
        krn_done_i = 1'b0;
        rd("run3_done_wins", 4'd1, 32'h2);
        rd("run3_runcnt", 4'd2, 32'd3);
`ifdef HLS_CSR_IRQ_EN
        chk("irq_set", {63'd0, irq_o}, 64'd1);
        rd("ctrl_irq_en", 4'd0, 32'h2);
`else
        chk("irq_tied", {63'd0, irq_o}, 64'd0);
        rd("ctrl_irq_en", 4'd0, 32'h0);
`endif
        wr(4'd1, 32'h2);
        chk("irq_cleared", {63'd0, irq_o}, 64'd0);
        rd("run3_cleared", 4'd1, 32'd0);

        // run 4: asynchronous reset while running
        wr(4'd6, 32'hCAFE0001);
        chk("ptr1_pre", ptr_o[127:64], 64'hCAFE0001);
        wr(4'd0, 32'h1);
        krn_ready_i = 1'b1;
        @(negedge clk_i);
        krn_ready_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        chk("arst_start", {63'd0, krn_start_o}, 64'd0);
        chk("arst_ptr", ptr_o, 128'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        krn_done_i = 1'b1;
        @(negedge clk_i);
        krn_done_i = 1'b0;
        rd("arst_status", 4'd1, 32'd0);
        rd("arst_runcnt", 4'd2, 32'd0);
        rd("arst_ptr0_lo", 4'd4, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
